// File: rtl/noc_rx_pkg.sv
// Shared types and default widths for the NoC receive-side packet controller.
package noc_rx_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned PKT_W  = ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        WAIT_LOW
    } rx_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } pkt_t;

endpackage

// File: rtl/noc_rx_fifo.sv
// Synchronous packet FIFO. The head entry is visible combinationally on head.
// push_accept reports whether a push lands this cycle; it is high when
// there is room, or when the FIFO is full but a pop frees the head entry
// in the same cycle.
module noc_rx_fifo #(
    parameter int unsigned DEPTH    = noc_rx_pkg::DEPTH,
    parameter type         pkt_type = noc_rx_pkg::pkt_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  pkt_type                push_data,
    input  logic                   pop,
    output pkt_type                head,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   push_accept
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    pkt_type            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   count;
    logic               full;
    logic               do_pop;

    assign full        = (count == LVL_W'(DEPTH));
    assign empty       = (count == '0);
    assign do_pop      = pop && !empty;
    assign push_accept = push && (!full || do_pop);
    assign head        = mem[rd_ptr];
    assign level       = count;

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push_accept, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_accept) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/noc_rx_pkt_ctrl.sv
// Receive-side controller between the NoC port and the Nios recv PIOs.
// Buffers incoming packets, presents one at a time under a 4-phase ack
// handshake, and counts packets dropped because the buffer was full.
module noc_rx_pkt_ctrl #(
    parameter int unsigned DATA_W = noc_rx_pkg::DATA_W,
    parameter int unsigned ADDR_W = noc_rx_pkg::ADDR_W,
    parameter int unsigned DEPTH  = noc_rx_pkg::DEPTH,
    parameter int unsigned CNT_W  = noc_rx_pkg::CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   noc_valid,
    input  logic [ADDR_W-1:0]      noc_addr,
    input  logic [DATA_W-1:0]      noc_data,
    input  logic                   pk_ack,
    output logic                   pk_detect,
    output logic [ADDR_W-1:0]      recv_addr,
    output logic [DATA_W-1:0]      recv_data,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]       overflow_cnt
);

    import noc_rx_pkg::*;

    // Local packet layout follows the instance widths, which may differ from the package defaults.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rx_pkt_t;

    rx_state_t state;
    rx_state_t state_nxt;
    logic      pop;
    logic      fifo_empty;
    logic      push_accept;
    rx_pkt_t   in_pkt;
    rx_pkt_t   fifo_head;

    assign in_pkt.addr = noc_addr;
    assign in_pkt.data = noc_data;

    noc_rx_fifo #(
        .DEPTH    (DEPTH),
        .pkt_type (rx_pkt_t)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (noc_valid),
        .push_data   (in_pkt),
        .pop         (pop),
        .head        (fifo_head),
        .level       (fifo_level),
        .empty       (fifo_empty),
        .push_accept (push_accept)
    );

    // Handshake state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and pop decode: present only when ack has returned low and a packet is waiting.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!pk_ack && !fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (pk_ack) begin
                    state_nxt = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!pk_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pk_detect = (state == PRESENT);

    // Capture the popped head; values hold through WAIT_LOW and IDLE until the next pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            recv_addr <= '0;
            recv_data <= '0;
        end else if (pop) begin
            recv_addr <= fifo_head.addr;
            recv_data <= fifo_head.data;
        end
    end

    // Saturating count of strobes the FIFO could not accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_cnt <= '0;
        end else if (noc_valid && !push_accept && (overflow_cnt != '1)) begin
            overflow_cnt <= overflow_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_noc_rx_pkt_ctrl.sv
// Scoreboard bench for noc_rx_pkt_ctrl: a queue-based reference model predicts
// buffering, drops and presentation order; a monitor compares at each negedge.
module tb_noc_rx_pkt_ctrl;

    localparam int DEPTH   = 4;
    localparam int CNT_MAX = 255;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } tpkt_t;

    logic        clk;
    logic        reset;
    logic        noc_valid;
    logic [7:0]  noc_addr;
    logic [31:0] noc_data;
    logic        pk_ack;
    logic        pk_detect;
    logic [7:0]  recv_addr;
    logic [31:0] recv_data;
    logic [2:0]  fifo_level;
    logic [7:0]  overflow_cnt;

    noc_rx_pkt_ctrl #(
        .DATA_W (32),
        .ADDR_W (8),
        .DEPTH  (DEPTH),
        .CNT_W  (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .noc_valid    (noc_valid),
        .noc_addr     (noc_addr),
        .noc_data     (noc_data),
        .pk_ack       (pk_ack),
        .pk_detect    (pk_detect),
        .recv_addr    (recv_addr),
        .recv_data    (recv_data),
        .fifo_level   (fifo_level),
        .overflow_cnt (overflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    tpkt_t mq[$];     // packets buffered in the FIFO
    tpkt_t sb_q[$];   // accepted packets not yet presented, in order
    int    m_cnt  = 0;
    bit    m_busy = 0;  // handshake in progress (packet popped, ack cycle not finished)
    bit    m_shown = 0; // packet currently presented

    int ack_mode = 0;   // 0 manual, 1 prompt ack, 2 random ack

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [31:0] d);
        noc_valid = 1'b1;
        noc_addr  = a;
        noc_data  = d;
        tick();
        noc_valid = 1'b0;
    endtask

    // Reference model: one step per clock edge from the sampled inputs.
    task automatic model_step();
        bit    pop_now;
        tpkt_t p;
        if (reset) begin
            mq.delete();
            sb_q.delete();
            m_cnt   = 0;
            m_busy  = 0;
            m_shown = 0;
        end else begin
            pop_now = !m_busy && !pk_ack && (mq.size() > 0);
            if (pop_now) void'(mq.pop_front());
            if (noc_valid) begin
                if (mq.size() < DEPTH) begin
                    p.addr = noc_addr;
                    p.data = noc_data;
                    mq.push_back(p);
                    sb_q.push_back(p);
                end else if (m_cnt < CNT_MAX) begin
                    m_cnt++;
                end
            end
            if (pop_now) begin
                m_busy  = 1;
                m_shown = 1;
            end else if (m_busy && m_shown && pk_ack) begin
                m_shown = 0;
            end else if (m_busy && !m_shown && !pk_ack) begin
                m_busy = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Software ack agent
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ack_mode == 1) pk_ack = pk_detect;
            else if (ack_mode == 2) pk_ack = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: per-cycle status checks and in-order presentation scoreboard.
    initial begin
        bit    prev_det = 0;
        tpkt_t exp_p;
        tpkt_t held = '0;
        forever begin
            @(negedge clk);
            check("pk_detect", 64'(pk_detect), 64'(m_shown));
            check("fifo_level", 64'(fifo_level), 64'(mq.size()));
            check("overflow_cnt", 64'(overflow_cnt), 64'(m_cnt));
            if (pk_detect && !prev_det) begin
                check("present_has_expected", 64'(sb_q.size() > 0), 64'd1);
                if (sb_q.size() > 0) begin
                    exp_p = sb_q.pop_front();
                    check("recv_addr", 64'(recv_addr), 64'(exp_p.addr));
                    check("recv_data", 64'(recv_data), 64'(exp_p.data));
                    held = exp_p;
                end
            end else if (pk_detect) begin
                check("recv_addr_stable", 64'(recv_addr), 64'(held.addr));
                check("recv_data_stable", 64'(recv_data), 64'(held.data));
            end
            prev_det = pk_detect;
        end
    end

    initial begin
        reset     = 1'b1;
        noc_valid = 1'b0;
        noc_addr  = '0;
        noc_data  = '0;
        pk_ack    = 1'b0;
        repeat (3) tick();
        check("rst_pk_detect", 64'(pk_detect), 64'd0);
        check("rst_recv_addr", 64'(recv_addr), 64'd0);
        check("rst_recv_data", 64'(recv_data), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_ovf", 64'(overflow_cnt), 64'd0);
        reset = 1'b0;
        tick();

        // 1: single packet, latency and handshake
        send(8'h05, 32'hDEADBEEF);
        check("t1_level_n1", 64'(fifo_level), 64'd1);
        check("t1_det_n1", 64'(pk_detect), 64'd0);
        tick();
        check("t1_det_n2", 64'(pk_detect), 64'd1);
        check("t1_addr", 64'(recv_addr), 64'h05);
        check("t1_data", 64'(recv_data), 64'hDEADBEEF);
        check("t1_level_n2", 64'(fifo_level), 64'd0);
        pk_ack = 1'b1;
        tick();
        check("t1_det_ack", 64'(pk_detect), 64'd0);
        check("t1_hold_data", 64'(recv_data), 64'hDEADBEEF);
        pk_ack = 1'b0;
        tick();
        tick();
        check("t1_det_idle", 64'(pk_detect), 64'd0);
        check("t1_level_end", 64'(fifo_level), 64'd0);

        // 2: six back-to-back strobes, ack held low
        for (int i = 1; i <= 6; i++) send(8'(i), 32'(i));
        check("t2_level", 64'(fifo_level), 64'd4);
        check("t2_ovf", 64'(overflow_cnt), 64'd1);
        check("t2_det", 64'(pk_detect), 64'd1);
        check("t2_data", 64'(recv_data), 64'd1);

        // 3: full + IDLE + ack low + strobe -> push accepted with the pop
        pk_ack = 1'b1;
        tick();
        pk_ack = 1'b0;
        tick();
        check("t3_det_idle", 64'(pk_detect), 64'd0);
        check("t3_level_pre", 64'(fifo_level), 64'd4);
        send(8'd7, 32'd7);
        check("t3_level", 64'(fifo_level), 64'd4);
        check("t3_ovf", 64'(overflow_cnt), 64'd1);
        check("t3_det", 64'(pk_detect), 64'd1);
        check("t3_data", 64'(recv_data), 64'd2);
        ack_mode = 1;
        repeat (20) tick();
        ack_mode = 0;
        pk_ack = 1'b0;
        repeat (2) tick();
        check("t3_drained", 64'(fifo_level), 64'd0);

        // 4: stream of 10 packets acked promptly
        ack_mode = 1;
        for (int i = 1; i <= 10; i++) begin
            send(8'(8'h40 + i), 32'(100 + i));
            repeat (2) tick();
        end
        repeat (10) tick();
        ack_mode = 0;
        pk_ack = 1'b0;
        repeat (2) tick();
        check("t4_ovf", 64'(overflow_cnt), 64'd1);
        check("t4_level", 64'(fifo_level), 64'd0);

        // 5: reset during PRESENT with level 3
        for (int i = 1; i <= 4; i++) send(8'(8'h50 + i), 32'(500 + i));
        check("t5_level", 64'(fifo_level), 64'd3);
        check("t5_det", 64'(pk_detect), 64'd1);
        reset = 1'b1;
        tick();
        check("t5_det_rst", 64'(pk_detect), 64'd0);
        check("t5_addr_rst", 64'(recv_addr), 64'd0);
        check("t5_data_rst", 64'(recv_data), 64'd0);
        check("t5_level_rst", 64'(fifo_level), 64'd0);
        check("t5_ovf_rst", 64'(overflow_cnt), 64'd0);
        reset = 1'b0;
        tick();

        // 6: stale ack, then saturation
        pk_ack = 1'b1;
        tick();
        send(8'h66, 32'h600D);
        repeat (5) tick();
        check("t6_det_stale", 64'(pk_detect), 64'd0);
        check("t6_level_stale", 64'(fifo_level), 64'd1);
        pk_ack = 1'b0;
        tick();
        check("t6_det", 64'(pk_detect), 64'd1);
        check("t6_data", 64'(recv_data), 64'h600D);
        for (int i = 0; i < 300; i++) send(8'(i), 32'(i));
        check("t6_ovf_sat", 64'(overflow_cnt), 64'hFF);
        check("t6_level_full", 64'(fifo_level), 64'd4);

        // Random traffic with random ack behaviour
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ack_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            noc_valid = ($urandom_range(0, 2) == 0);
            noc_addr  = 8'($urandom);
            noc_data  = $urandom;
            tick();
        end
        noc_valid = 1'b0;
        ack_mode = 1;
        repeat (60) tick();
        check("all_delivered", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
